flow_attr_extract: RTL



---
 rtl/flow_pkg.sv | 54 +++++
 rtl/flow_attr_extract_capture.sv | 46 ++++
 rtl/flow_attr_extract.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/flow_pkg.sv
// flow_pkg: shared constants, capture-slot layout and types for the flow-attribute parser.
package flow_pkg;

  localparam int FLOW_ATTR_W = 96;

  // Packet byte offsets of the fixed header fields.
  localparam int OFF_ETHTYPE = 12;
  localparam int OFF_VERIHL  = 14;
  localparam int OFF_FRAG    = 20;
  localparam int OFF_PROTO   = 23;
  localparam int OFF_SIP     = 26;
  localparam int OFF_DIP     = 30;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_TCP    = 8'd6;
  localparam logic [7:0]  PROTO_UDP    = 8'd17;

  // Capture slots: one hdr_byte_capture per slot. Port slots come last and
  // take their offset at runtime from IHL.
  localparam int CAP_ETH    = 0;
  localparam int CAP_VERIHL = 2;
  localparam int CAP_FRAG   = 3;
  localparam int CAP_PROTO  = 5;
  localparam int CAP_SIP    = 6;
  localparam int CAP_DIP    = 10;
  localparam int CAP_PORT   = 14;
  localparam int N_CAP      = 18;

  typedef enum logic [1:0] {
    SKIP_NON_IPV4 = 2'd0,
    SKIP_BAD_IHL  = 2'd1,
    SKIP_NON_L4   = 2'd2,
    SKIP_RUNT     = 2'd3
  } skip_reason_e;

  typedef enum logic [1:0] {
    S_RESYNC = 2'd0,
    S_SOP    = 2'd1,
    S_HDR    = 2'd2
  } parse_state_e;

  // Packet byte offset of a fixed (non-port) capture slot.
  function automatic logic [6:0] fixed_off(input int slot);
    int off;
    if (slot < CAP_VERIHL)     off = OFF_ETHTYPE + slot;
    else if (slot < CAP_FRAG)  off = OFF_VERIHL;
    else if (slot < CAP_PROTO) off = OFF_FRAG + slot - CAP_FRAG;
    else if (slot < CAP_SIP)   off = OFF_PROTO;
    else if (slot < CAP_DIP)   off = OFF_SIP + slot - CAP_SIP;
    else                       off = OFF_DIP + slot - CAP_DIP;
    return 7'(off);
  endfunction

endpackage

// File: rtl/flow_attr_extract_capture.sv
// hdr_byte_capture: latches the packet byte at byte_off and remembers whether it was seen.
// byte_d/seen_d are the post-beat values so the final beat can be judged in the same cycle.
module hdr_byte_capture (
  input  logic        pkt_clk,
  input  logic        pkt_rst_n,
  input  logic        cap_en,
  input  logic        clr,
  input  logic [3:0]  beat_idx,
  input  logic [63:0] tdata,
  input  logic [7:0]  tkeep,
  input  logic [6:0]  byte_off,
  output logic [7:0]  byte_d,
  output logic        seen_d
);

  logic [7:0] byte_p0;
  logic       seen_p0;
  logic       hit;

  assign hit = cap_en && (beat_idx == byte_off[6:3]) && tkeep[byte_off[2:0]];

  // Merge this beat into the held value; a start-of-packet beat wipes the slot.
  always_comb begin
    byte_d = byte_p0;
    seen_d = seen_p0;
    if (hit) begin
      byte_d = tdata[{byte_off[2:0], 3'b000} +: 8];
      seen_d = 1'b1;
    end else if (clr) begin
      byte_d = 8'h00;
      seen_d = 1'b0;
    end
  end

  // Seen flag gates evaluation, so it takes the reset.
  always_ff @(posedge pkt_clk or negedge pkt_rst_n) begin
    if (!pkt_rst_n) seen_p0 <= 1'b0;
    else            seen_p0 <= seen_d;
  end

  // Byte value is always cleared or overwritten before it is looked at.
  always_ff @(posedge pkt_clk) begin
    byte_p0 <= byte_d;
  end

endmodule

// File: rtl/flow_attr_extract.sv
// flow_attr_extract: AXI-Stream monitor that pulls the IPv4 flow attribute
// {src_ip, dst_ip, src_port, dst_port} out of each packet and emits one vld or skip pulse.
module flow_attr_extract import flow_pkg::*; #(
  parameter bit ZERO_PORTS_ON_FRAG = 1'b1,
  parameter bit SKIP_ON_RUNT       = 1'b1
) (
  input  logic                   pkt_clk,
  input  logic                   pkt_rst_n,
  input  logic [63:0]            s_axis_tdata,
  input  logic [7:0]             s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic                   flow_attribute_vld_out,
  output logic [FLOW_ATTR_W-1:0] flow_attribute_out,
  output logic                   flow_skip_out,
  output logic [1:0]             flow_skip_reason_out
);

  parse_state_e           state_q;
  logic [3:0]             beat_cnt_q;
  logic                   tready_q;
  logic [3:0]             ihl_p0;
  logic                   ihl_seen_p0;
  logic                   vld_p1;
  logic                   skip_p1;
  logic [1:0]             reason_p1;
  logic [FLOW_ATTR_W-1:0] attr_p1;

  logic       accept, cap_en, sop, eop;
  logic [3:0] beat_idx;
  logic [6:0] l4_off;

  assign accept   = s_axis_tvalid && tready_q;
  assign cap_en   = accept && ((state_q == S_SOP) || (state_q == S_HDR));
  assign sop      = accept && (state_q == S_SOP);
  assign eop      = cap_en && s_axis_tlast;
  assign beat_idx = (state_q == S_SOP) ? 4'd0 : beat_cnt_q;
  assign l4_off   = 7'd14 + {1'b0, ihl_p0, 2'b00};

  logic [7:0] cap_d      [N_CAP];
  logic       cap_seen_d [N_CAP];

  // Port slots only arm once IHL is known, so a stale offset can never hit early header bytes.
  for (genvar g = 0; g < N_CAP; g++) begin : g_cap
    logic [6:0] off;
    logic       en;
    assign off = (g >= CAP_PORT) ? l4_off + 7'(g - CAP_PORT) : fixed_off(g);
    assign en  = cap_en && ((g < CAP_PORT) || ihl_seen_p0);
    hdr_byte_capture u_cap (
      .pkt_clk   (pkt_clk),
      .pkt_rst_n (pkt_rst_n),
      .cap_en    (en),
      .clr       (sop),
      .beat_idx  (beat_idx),
      .tdata     (s_axis_tdata),
      .tkeep     (s_axis_tkeep),
      .byte_off  (off),
      .byte_d    (cap_d[g]),
      .seen_d    (cap_seen_d[g])
    );
  end

  logic [15:0]  ethtype, frag_w;
  logic [7:0]   verihl, proto;
  logic         is_frag, ports_req, hdr_seen, ports_seen, pass;
  skip_reason_e reason;
  logic [31:0]  sip, dip, ports;

  // Classify the packet from this beat merged with earlier captures; first failing check wins.
  always_comb begin
    ethtype = {cap_d[CAP_ETH], cap_d[CAP_ETH+1]};
    verihl  = cap_d[CAP_VERIHL];
    frag_w  = {cap_d[CAP_FRAG], cap_d[CAP_FRAG+1]};
    proto   = cap_d[CAP_PROTO];
    sip     = {cap_d[CAP_SIP], cap_d[CAP_SIP+1], cap_d[CAP_SIP+2], cap_d[CAP_SIP+3]};
    dip     = {cap_d[CAP_DIP], cap_d[CAP_DIP+1], cap_d[CAP_DIP+2], cap_d[CAP_DIP+3]};
    hdr_seen = 1'b1;
    for (int i = 0; i < CAP_PORT; i++) hdr_seen &= cap_seen_d[i];
    ports_seen = 1'b1;
    for (int i = CAP_PORT; i < N_CAP; i++) ports_seen &= cap_seen_d[i];
    // MF flag plus 13-bit fragment offset.
    is_frag   = (frag_w & 16'h3FFF) != 16'h0000;
    ports_req = !(ZERO_PORTS_ON_FRAG && is_frag);
    ports     = ports_req ? {cap_d[CAP_PORT], cap_d[CAP_PORT+1], cap_d[CAP_PORT+2], cap_d[CAP_PORT+3]}
                          : 32'h0;
    pass   = 1'b0;
    reason = SKIP_RUNT;
    if (ethtype != ETHTYPE_IPV4 || verihl[7:4] != 4'd4) reason = SKIP_NON_IPV4;
    else if (verihl[3:0] < 4'd5)                        reason = SKIP_BAD_IHL;
    else if (proto != PROTO_TCP && proto != PROTO_UDP)  reason = SKIP_NON_L4;
    else if (!hdr_seen || (ports_req && !ports_seen))   reason = SKIP_RUNT;
    else                                                pass   = 1'b1;
  end

  // IHL copy that steers the port slots on later beats.
  always_ff @(posedge pkt_clk or negedge pkt_rst_n) begin
    if (!pkt_rst_n) begin
      ihl_p0      <= 4'd0;
      ihl_seen_p0 <= 1'b0;
    end else begin
      ihl_p0      <= cap_d[CAP_VERIHL][3:0];
      ihl_seen_p0 <= cap_seen_d[CAP_VERIHL];
    end
  end

  // Packet framing FSM with registered result pulses.
  always_ff @(posedge pkt_clk or negedge pkt_rst_n) begin
    if (!pkt_rst_n) begin
      state_q    <= S_RESYNC;
      beat_cnt_q <= 4'd0;
      tready_q   <= 1'b0;
      vld_p1     <= 1'b0;
      skip_p1    <= 1'b0;
      reason_p1  <= 2'd0;
      attr_p1    <= '0;
    end else begin
      tready_q <= 1'b1;
      vld_p1   <= 1'b0;
      skip_p1  <= 1'b0;
      case (state_q)
        S_RESYNC: if (accept && s_axis_tlast) state_q <= S_SOP;
        S_SOP: if (accept) begin
          beat_cnt_q <= 4'd1;
          if (!s_axis_tlast) state_q <= S_HDR;
        end
        S_HDR: if (accept) begin
          if (beat_cnt_q != 4'd15) beat_cnt_q <= beat_cnt_q + 4'd1;
          if (s_axis_tlast) state_q <= S_SOP;
        end
        default: state_q <= S_RESYNC;
      endcase
      if (eop) begin
        if (pass) begin
          vld_p1  <= 1'b1;
          attr_p1 <= {sip, dip, ports};
        end else if (reason != SKIP_RUNT || SKIP_ON_RUNT) begin
          skip_p1   <= 1'b1;
          reason_p1 <= reason;
        end
      end
    end
  end

  assign s_axis_tready          = tready_q;
  assign flow_attribute_vld_out = vld_p1;
  assign flow_attribute_out     = attr_p1;
  assign flow_skip_out          = skip_p1;
  assign flow_skip_reason_out   = reason_p1;

endmodule
